zlave_bus_arbiter: RTL
======================

// Module: zlave_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 8-bit register-slave port (4-bit address, single-cycle
//  read/write strobes, fixed read latency) among NUM_REQ requesters. Serialises commands,
//  one transaction in flight, returns read data to the owning requester. Sits between
//  on-chip controllers and one slave-template instance.
// PARAMETERS
//  NUM_REQ       4   number of requesters, legal 2..8
//  READ_LATENCY  3   cycles from slave_read strobe to valid slave_readdata, legal >= 2
// PORTS
//  clk            in   1          system clock, all logic on rising edge
//  reset_n        in   1          asynchronous reset, active-low
//  req_valid      in   NUM_REQ    per-requester command request
//  req_write      in   NUM_REQ    1 = write, 0 = read
//  req_address    in   4*NUM_REQ  requester i address at [4i+3:4i]
//  req_writedata  in   8*NUM_REQ  requester i write data at [8i+7:8i]
//  req_ack        out  NUM_REQ    one-cycle pulse: command issued to slave
//  resp_valid     out  NUM_REQ    one-cycle pulse: resp_readdata valid for requester i
//  resp_readdata  out  8          read data, shared by all requesters
//  slave_address  out  4          to slave
//  slave_read     out  1          to slave, one-cycle strobe
//  slave_write    out  1          to slave, one-cycle strobe
//  slave_writedata out 8          to slave
//  slave_byteenable out 1         to slave, constant 1
//  slave_readdata in   8          from slave
//  busy           out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs 0 except slave_byteenable=1; FSM IDLE;
//    round-robin pointer = 0 (requester 0 highest priority); in-flight transaction dropped.
//  FSM states: IDLE, ISSUE, RD_WAIT, RD_RESP.
//  IDLE: if any req_valid, winner = first set bit scanning from pointer upward, wrapping.
//    Latch winner index, write flag, address, writedata; go ISSUE. No request: stay IDLE.
//  ISSUE (one cycle): drive slave_address/slave_writedata from latch; slave_write=1 or
//    slave_read=1; req_ack[winner]=1; pointer <= winner+1, wrapping NUM_REQ-1 -> 0.
//    Write -> IDLE. Read -> RD_WAIT, latency counter loaded.
//  RD_WAIT: count cycles; in cycle ISSUE+READ_LATENCY capture slave_readdata into
//    resp_readdata; go RD_RESP.
//  RD_RESP (one cycle): resp_valid[winner]=1; resp_readdata holds until next read capture;
//    go IDLE.
//  All slave_* and req_ack/resp_valid outputs are registered; strobes are 0 outside ISSUE.
//  slave_address/slave_writedata hold last issued values when idle.
//  Timing: req_valid sampled in IDLE cycle T; strobe and ack in T+1.
//    Write throughput: one per 2 cycles. Read: resp_valid at T+2+READ_LATENCY; next
//    request sampled no earlier than that cycle + 1.
//  Requester rule: hold req_valid and fields stable until req_ack; drop or re-assert
//    afterwards. Command is latched at grant; deasserting req_valid after grant does not
//    cancel it. A requester still asserting after ack competes again at its new priority.
//  Simultaneous requests: strict round-robin, no requester starved; worst-case wait
//    NUM_REQ-1 transactions.
//  req_valid changes in ISSUE/RD_WAIT/RD_RESP are ignored until IDLE.
//  Reset asserted mid-read: no resp_valid is ever generated for that read.
// TESTING
//  Single write by req1 (addr 0, data 8'hA5) -> slave_write=1 one cycle, addr 0,
//    data A5, req_ack=4'b0010 same cycle, busy back to 0 next cycle.
//  Read by req2, slave_readdata=8'h3C valid at ISSUE+3 -> resp_readdata=3C,
//    resp_valid=4'b0100 at ISSUE+4, exactly one pulse.
//  req_valid=4'b1111 held after reset -> ack order 0,1,2,3,0; acks exactly 2 cycles apart
//    (all writes).
//  Pointer wrap: req3 then req0+req3 pending -> req0 granted before req3.
//  reset_n low during RD_WAIT -> outputs 0 immediately; no resp_valid after release;
//    next grant to req0.
//  Mixed: req0 write, req1 read -> req1 strobe not before write ack+2; each ack exactly once.

Source files
------------

// File: rtl/zlave_bus_arbiter.sv
// rtl/zlave_bus_arbiter.sv - round-robin arbiter sharing one 8-bit register-slave port
module zlave_bus_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_write,
    input  logic [4*NUM_REQ-1:0] req_address,
    input  logic [8*NUM_REQ-1:0] req_writedata,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [7:0]           resp_readdata,
    output logic [3:0]           slave_address,
    output logic                 slave_read,
    output logic                 slave_write,
    output logic [7:0]           slave_writedata,
    output logic                 slave_byteenable,
    input  logic [7:0]           slave_readdata,
    output logic                 busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Counter only has to hold READ_LATENCY-1; READ_LATENCY >= 2 keeps this >= 1 bit.
    localparam int CNT_W = $clog2(READ_LATENCY);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RD_RESP} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   win, win_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [3:0]         addr_n;
    logic [7:0]         wdata_n;
    logic               rd_n, wr_n;
    logic [NUM_REQ-1:0] ack_n, rv_n;
    logic [7:0]         rdata_n;

    logic               found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W:0]     sum;
    logic [IDX_W-1:0]   cand;
    logic               sel_write;
    logic [3:0]         sel_addr;
    logic [7:0]         sel_wdata;

    assign slave_byteenable = 1'b1;
    assign busy             = (state != IDLE);

    // Round-robin pick: first requester at or after the pointer, wrapping, then mux its fields.
    always_comb begin
        found     = 1'b0;
        sel_idx   = '0;
        sum       = '0;
        cand      = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ))
                sum = sum - (IDX_W+1)'(NUM_REQ);
            cand = sum[IDX_W-1:0];
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == sel_idx) begin
                sel_write = req_write[k];
                sel_addr  = req_address[4*k +: 4];
                sel_wdata = req_writedata[8*k +: 8];
            end
        end
    end

    // Next-state and next registered-output values; strobes default low outside ISSUE.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        win_n   = win;
        cnt_n   = cnt;
        addr_n  = slave_address;
        wdata_n = slave_writedata;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        ack_n   = '0;
        rv_n    = '0;
        rdata_n = resp_readdata;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = ISSUE;
                    win_n   = sel_idx;
                    addr_n  = sel_addr;
                    wdata_n = sel_wdata;
                    wr_n    = sel_write;
                    rd_n    = !sel_write;
                    ack_n   = NUM_REQ'(1) << sel_idx;
                end
            end
            ISSUE: begin
                ptr_n = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
                if (slave_write) begin
                    state_n = IDLE;
                end else begin
                    state_n = RD_WAIT;
                    cnt_n   = CNT_W'(READ_LATENCY-1);
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    rdata_n = slave_readdata;
                    rv_n    = NUM_REQ'(1) << win;
                    state_n = RD_RESP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RD_RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            ptr             <= '0;
            win             <= '0;
            cnt             <= '0;
            slave_address   <= '0;
            slave_writedata <= '0;
            slave_read      <= 1'b0;
            slave_write     <= 1'b0;
            req_ack         <= '0;
            resp_valid      <= '0;
            resp_readdata   <= '0;
        end else begin
            state           <= state_n;
            ptr             <= ptr_n;
            win             <= win_n;
            cnt             <= cnt_n;
            slave_address   <= addr_n;
            slave_writedata <= wdata_n;
            slave_read      <= rd_n;
            slave_write     <= wr_n;
            req_ack         <= ack_n;
            resp_valid      <= rv_n;
            resp_readdata   <= rdata_n;
        end
    end
endmodule
